// File: rtl/serial_subtractor16.sv
// Bit-serial subtractor: diff = a - b - borrow_in, LSB first, BITS_PER_CYCLE bits per clock.
// Optional SERIAL_SUB_OVF_EN adds a registered signed-overflow flag (ovf) updated with diff.
module serial_subtractor16 #(
  parameter int WIDTH          = 16,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             ovf_q, ovf_d;
`endif

  logic [BITS_PER_CYCLE-1:0] d_bits;
  logic                      br_next;
  logic [WIDTH-1:0]          sh_next;

  // Borrow chain over the current low slice of the operand registers.
  always_comb begin
    logic br_c;
    d_bits = '0;
    br_c   = br_q;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      d_bits[i] = a_q[i] ^ b_q[i] ^ br_c;
      br_c      = (~a_q[i] & b_q[i]) | (~(a_q[i] ^ b_q[i]) & br_c);
    end
    br_next = br_c;
  end

  // New result bits enter at the MSB end; after N shifts the word is aligned.
  assign sh_next = (sh_q >> BITS_PER_CYCLE) | (WIDTH'(d_bits) << (WIDTH - BITS_PER_CYCLE));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sh_d    = sh_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bout_d  = bout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
`endif

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          state_d = ST_RUN;
          a_d     = a;
          b_d     = b;
          br_d    = borrow_in;
          sh_d    = '0;
          cnt_d   = CW'(N - 1);
          busy_d  = 1'b1;
`ifdef SERIAL_SUB_OVF_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
        end
      end
      ST_RUN: begin
        a_d   = a_q >> BITS_PER_CYCLE;
        b_d   = b_q >> BITS_PER_CYCLE;
        br_d  = br_next;
        sh_d  = sh_next;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          diff_d  = sh_next;
          bout_d  = br_next;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d   = (a_msb_q != b_msb_q) && (sh_next[WIDTH-1] != a_msb_q);
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sh_q    <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sh_q    <= sh_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf        = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor16.sv
// Directed bench for serial_subtractor16: one 1-bit/cycle and one 4-bit/cycle instance.
module tb_serial_subtractor16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start4;
  logic [15:0] a, b;
  logic        borrow_in;
  logic        busy, done, borrow_out;
  logic [15:0] diff;
  logic        busy4, done4, borrow_out4;
  logic [15:0] diff4;
`ifdef SERIAL_SUB_OVF_EN
  logic        ovf, ovf4;
`endif

  always #5 clk = ~clk;

  serial_subtractor16 #(.WIDTH(16), .BITS_PER_CYCLE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .borrow_in(borrow_in),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf)
`endif
  );

  serial_subtractor16 #(.WIDTH(16), .BITS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a), .b(b), .borrow_in(borrow_in),
    .busy(busy4), .done(done4), .diff(diff4), .borrow_out(borrow_out4)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf4)
`endif
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] exp_diff;
    logic        exp_bout;
    logic        exp_ovf;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Pulse start on both instances and record done latency, busy cycles and diff stability.
  task automatic run_both(input logic [15:0] va, input logic [15:0] vb, input logic vbin,
                          output int lat1, output int lat4, output int busy_cnt,
                          output logic stable);
    logic [15:0] held;
    @(negedge clk);
    a = va; b = vb; borrow_in = vbin;
    start = 1'b1; start4 = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; start4 = 1'b0;
    lat1 = -1; lat4 = -1; busy_cnt = 0; stable = 1'b1;
    held = diff;
    if (busy) busy_cnt++;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done4 && lat4 < 0) lat4 = k;
      if (done && lat1 < 0) lat1 = k;
      if (lat1 < 0 && busy) busy_cnt++;
      if (lat1 < 0 && diff !== held) stable = 1'b0;
      if (lat1 >= 0 && lat4 >= 0) break;
    end
  endtask

  initial begin
    vec_t vecs[12];
    int   lat1, lat4, bcnt, cyc;
    logic stable, saw_done;

    vecs[0]  = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[1]  = '{16'h0001, 16'h0001, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[2]  = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[3]  = '{16'hBFFF, 16'hFFFF, 1'b0, 16'hC000, 1'b1, 1'b0};
    vecs[4]  = '{16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[5]  = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[6]  = '{16'h0001, 16'h0002, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[7]  = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    vecs[8]  = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
    vecs[9]  = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0};
    vecs[10] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[11] = '{16'h8000, 16'h0000, 1'b1, 16'h7FFF, 1'b0, 1'b1};

    rst_n = 1'b0; start = 1'b0; start4 = 1'b0;
    a = '0; b = '0; borrow_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_diff", 32'(diff), 32'd0);
    chk("reset_bout", 32'(borrow_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_both(vecs[i].a, vecs[i].b, vecs[i].bin, lat1, lat4, bcnt, stable);
      chk($sformatf("v%0d_lat1", i), 32'(lat1), 32'd16);
      chk($sformatf("v%0d_lat4", i), 32'(lat4), 32'd4);
      chk($sformatf("v%0d_busy_cycles", i), 32'(bcnt), 32'd16);
      chk($sformatf("v%0d_diff_stable", i), 32'(stable), 32'd1);
      chk($sformatf("v%0d_diff", i), 32'(diff), 32'(vecs[i].exp_diff));
      chk($sformatf("v%0d_bout", i), 32'(borrow_out), 32'(vecs[i].exp_bout));
      chk($sformatf("v%0d_diff4", i), 32'(diff4), 32'(vecs[i].exp_diff));
      chk($sformatf("v%0d_bout4", i), 32'(borrow_out4), 32'(vecs[i].exp_bout));
`ifdef SERIAL_SUB_OVF_EN
      chk($sformatf("v%0d_ovf", i), 32'(ovf), 32'(vecs[i].exp_ovf));
      chk($sformatf("v%0d_ovf4", i), 32'(ovf4), 32'(vecs[i].exp_ovf));
`endif
    end

    // Start pulses while busy must be ignored.
    @(negedge clk);
    a = 16'h1234; b = 16'h0234; borrow_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    a = 16'hFFFF; b = 16'h0000; borrow_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (done) begin cyc = k; break; end
    end
    chk("ign_done_seen", 32'(cyc >= 0), 32'd1);
    chk("ign_diff", 32'(diff), 32'h1000);
    chk("ign_bout", 32'(borrow_out), 32'd0);

    // Back-to-back with start held high.
    @(negedge clk);
    a = 16'h1234; b = 16'h0234; borrow_in = 1'b0; start = 1'b1;
    cyc = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (done) begin cyc = k; break; end
    end
    chk("b2b_first_seen", 32'(cyc >= 0), 32'd1);
    chk("b2b_first_diff", 32'(diff), 32'h1000);
    chk("b2b_first_bout", 32'(borrow_out), 32'd0);
    a = 16'h0001; b = 16'h0002;
    cyc = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        chk("b2b_done_drop", 32'(done), 32'd0);
        chk("b2b_busy_rise", 32'(busy), 32'd1);
        chk("b2b_diff_held", 32'(diff), 32'h1000);
      end
      if (done) begin cyc = k; break; end
    end
    chk("b2b_spacing", 32'(cyc), 32'd17);
    chk("b2b_second_diff", 32'(diff), 32'hFFFF);
    chk("b2b_second_bout", 32'(borrow_out), 32'd1);
    @(negedge clk);
    start = 1'b0;

    // Reset in the middle of a computation aborts it.
    @(negedge clk);
    a = 16'h0001; b = 16'h0002; borrow_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_diff", 32'(diff), 32'd0);
    chk("mid_rst_bout", 32'(borrow_out), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    chk("mid_rst_no_done", 32'(saw_done), 32'd0);

    run_both(16'h1234, 16'h0234, 1'b0, lat1, lat4, bcnt, stable);
    chk("post_rst_lat1", 32'(lat1), 32'd16);
    chk("post_rst_diff", 32'(diff), 32'h1000);
    chk("post_rst_bout", 32'(borrow_out), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor16.md
Name: serial_subtractor16

Overview:
- Multi-cycle, bit-serial subtractor; inverse operation of the 16-bit ripple-carry adder datapath.
- Computes diff = a - b - borrow_in, LSB first, BITS_PER_CYCLE bits per clock, under a start/busy/done handshake.
- Used as the subtract path beside the adder and as a cross-check engine for adder results: (a + b) then subtract b gives back a.

Parameters:
- WIDTH, 16, operand/result width in bits.
- BITS_PER_CYCLE, 1, bits processed per clock; must divide WIDTH; legal values 1, 2, 4, 8, 16.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- a  input  WIDTH  minuend; sampled with start.
- b  input  WIDTH  subtrahend; sampled with start.
- borrow_in  input  1  incoming borrow; sampled with start.
- busy  output  1  high while computation in progress.
- done  output  1  one-cycle pulse; result valid.
- diff  output  WIDTH  result; registered, held until next accepted start.
- borrow_out  output  1  final borrow; registered, held with diff.

Behaviour:
- Reset: sampled at rising edge when rst_n=0. Sets busy=0, done=0, diff=0, borrow_out=0, state=IDLE, cycle counter=0 and internal shift registers=0.
- Reset mid-operation: computation is aborted. No done pulse is produced.
- States:
  - IDLE: after reset.
  - RUN: computing.
  - DONE: one cycle; done=1.
- Accept: start=1 at an edge while in IDLE or DONE.
  - Latches a, b and borrow_in.
  - Clears the diff shift register.
  - Loads counter with N-1, where N = WIDTH/BITS_PER_CYCLE.
  - Goes to RUN; busy=1 from the next cycle.
- start while busy=1 is ignored. Operands are not re-sampled and there is no error flag.
- RUN, each edge:
  - Processes the next BITS_PER_CYCLE LSBs through a borrow chain:
    - d_i = a_i ^ b_i ^ br
    - br' = (~a_i & b_i) | (~(a_i ^ b_i) & br)
  - Shifts the operand registers right by BITS_PER_CYCLE.
  - Shifts the result bits in at the MSB end.
  - Borrow is carried in a register between cycles.
- Final RUN cycle (counter=0):
  - Transfers the result to diff and the final borrow to borrow_out.
  - Sets done=1 and busy=0.
  - Goes to DONE.
- Latency: start accepted at edge t; done=1 and diff valid after edge t+N. Default N=16; N=1 when BITS_PER_CYCLE=WIDTH.
- DONE:
  - Next edge returns to IDLE with done=0.
  - If start=1 in DONE, it is accepted (back-to-back): goes to RUN, done drops.
- Width rules: diff is modulo 2^WIDTH. borrow_out=1 iff a < b + borrow_in as unsigned values.
- diff and borrow_out change only at the completion edge or reset. They are stable during RUN.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit). Reset value 0; updated with diff.
  - ovf=1 when the signed two's-complement result overflows: (a_msb != b_msb) && (diff_msb != a_msb).
- Undefined:
  - Port and logic are absent.
  - All other behaviour is identical.

Test Plan:
- Reset then a=0, b=0, borrow_in=0, start pulse -> done exactly 16 cycles after the start edge; diff=0x0000, borrow_out=0; busy high for 16 cycles.
- a=1, b=1, borrow_in=1 -> diff=0xFFFF, borrow_out=1. a=0, b=1, borrow_in=0 -> diff=0xFFFF, borrow_out=1.
- a=0xBFFF, b=0xFFFF, borrow_in=0 -> diff=0xC000, borrow_out=1. a=0xFFFF, b=0xFFFF -> diff=0x0000, borrow_out=0.
- start held high continuously with new operands each done cycle (0x1234-0x0234 then 0x0001-0x0002) -> back-to-back results 0x1000/0 then 0xFFFF/1, 17 cycles apart. start pulses during busy are ignored and diff is unchanged.
- rst_n=0 for one cycle at RUN cycle 8 -> busy=0, diff=0, no done. A subsequent fresh start completes normally.
- With SERIAL_SUB_OVF_EN: a=0x8000, b=0x0001 -> diff=0x7FFF, ovf=1. a=0x7FFF, b=0xFFFF -> diff=0x8000, ovf=1. a=5, b=3 -> ovf=0.
- With BITS_PER_CYCLE=4: same vectors, done 4 cycles after start.
